// File: rtl/pulse_period_meter.sv
// Measures the cycle count between rising edges of a synchronous pulse stream,
// compares it with an expected period, tracks min/max, lock and stall status.
module pulse_period_meter #(
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic        CLOCK,
  input  logic        NRESET,
  input  logic        INP,
  input  logic [31:0] EXPECT,
  input  logic [31:0] TMAX,
  input  logic        CLEAR,
  output logic [31:0] PERIOD,
  output logic        VALID,
  output logic        MATCH,
  output logic [31:0] MINP,
  output logic [31:0] MAXP,
  output logic        LOCKED,
  output logic        TIMEOUT
);

  typedef enum logic {IDLE, MEASURE} state_e;

  localparam logic [7:0]  LOCK_CNT8 = 8'(LOCK_COUNT);
  localparam logic [31:0] ALL_ONES  = 32'hFFFF_FFFF;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        inp_dly_q, inp_dly_d;
  logic [7:0]  streak_q, streak_d;
  logic [31:0] period_q, period_d;
  logic        valid_q, valid_d;
  logic        match_q, match_d;
  logic [31:0] minp_q, minp_d;
  logic [31:0] maxp_q, maxp_d;
  logic        locked_q, locked_d;
  logic        timeout_q, timeout_d;

  logic        rise;
  logic        match_now;
  logic [7:0]  streak_inc;

  assign rise       = INP & ~inp_dly_q;
  assign match_now  = (EXPECT != 32'd0) && (cnt_q == EXPECT);
  assign streak_inc = (streak_q >= LOCK_CNT8) ? LOCK_CNT8 : streak_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    inp_dly_d = INP;
    streak_d  = streak_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    match_d   = match_q;
    minp_d    = minp_q;
    maxp_d    = maxp_q;
    locked_d  = locked_q;
    timeout_d = timeout_q;

    if (CLEAR) begin
      state_d   = IDLE;
      cnt_d     = 32'd0;
      minp_d    = ALL_ONES;
      maxp_d    = 32'd0;
      timeout_d = 1'b0;
      locked_d  = 1'b0;
      streak_d  = 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = MEASURE;
            cnt_d   = 32'd1;
          end
        end
        MEASURE: begin
          // A rise wins over an expiring timeout in the same cycle.
          if (rise) begin
            period_d = cnt_q;
            valid_d  = 1'b1;
            match_d  = match_now;
            if (cnt_q < minp_q) minp_d = cnt_q;
            if (cnt_q > maxp_q) maxp_d = cnt_q;
            cnt_d = 32'd1;
            if (match_now) begin
              streak_d = streak_inc;
              if (streak_inc == LOCK_CNT8) locked_d = 1'b1;
            end else begin
              streak_d = 8'd0;
              locked_d = 1'b0;
            end
          end else if ((TMAX != 32'd0) && (cnt_q >= TMAX)) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
            cnt_d     = 32'd0;
            streak_d  = 8'd0;
            locked_d  = 1'b0;
          end else if (cnt_q != ALL_ONES) begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!NRESET) begin
      state_q   <= IDLE;
      cnt_q     <= 32'd0;
      inp_dly_q <= 1'b1;
      streak_q  <= 8'd0;
      period_q  <= 32'd0;
      valid_q   <= 1'b0;
      match_q   <= 1'b0;
      minp_q    <= ALL_ONES;
      maxp_q    <= 32'd0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      inp_dly_q <= inp_dly_d;
      streak_q  <= streak_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      match_q   <= match_d;
      minp_q    <= minp_d;
      maxp_q    <= maxp_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
    end
  end

  assign PERIOD  = period_q;
  assign VALID   = valid_q;
  assign MATCH   = match_q;
  assign MINP    = minp_q;
  assign MAXP    = maxp_q;
  assign LOCKED  = locked_q;
  assign TIMEOUT = timeout_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Bench for pulse_period_meter: directed scenarios plus random pulse trains,
// checked every cycle against a timestamp-based reference model.
module tb_pulse_period_meter;

  localparam int LOCK_COUNT = 4;

  logic        CLOCK = 1'b0;
  logic        NRESET;
  logic        INP;
  logic [31:0] EXPECT;
  logic [31:0] TMAX;
  logic        CLEAR;
  logic [31:0] PERIOD;
  logic        VALID;
  logic        MATCH;
  logic [31:0] MINP;
  logic [31:0] MAXP;
  logic        LOCKED;
  logic        TIMEOUT;

  pulse_period_meter #(.LOCK_COUNT(LOCK_COUNT)) dut (
    .CLOCK(CLOCK), .NRESET(NRESET), .INP(INP), .EXPECT(EXPECT), .TMAX(TMAX),
    .CLEAR(CLEAR), .PERIOD(PERIOD), .VALID(VALID), .MATCH(MATCH),
    .MINP(MINP), .MAXP(MAXP), .LOCKED(LOCKED), .TIMEOUT(TIMEOUT)
  );

  always #5 CLOCK = ~CLOCK;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: remembers the cycle number of the last accepted rise.
  int          cyc = 0;
  bit          m_prev;
  bit          m_armed;
  int          m_last;
  int          m_streak;
  logic [31:0] m_period;
  logic        m_valid;
  logic        m_match;
  logic [31:0] m_minp;
  logic [31:0] m_maxp;
  logic        m_locked;
  logic        m_timeout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %h, want %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev = 1'b1; m_armed = 1'b0; m_last = 0; m_streak = 0;
    m_period = 32'd0; m_valid = 1'b0; m_match = 1'b0;
    m_minp = 32'hFFFF_FFFF; m_maxp = 32'd0;
    m_locked = 1'b0; m_timeout = 1'b0;
  endtask

  task automatic model_step();
    bit rise;
    int p;
    cyc++;
    if (!NRESET) begin
      model_reset();
      return;
    end
    rise = INP && !m_prev;
    m_valid = 1'b0;
    if (CLEAR) begin
      m_armed = 1'b0; m_minp = 32'hFFFF_FFFF; m_maxp = 32'd0;
      m_timeout = 1'b0; m_locked = 1'b0; m_streak = 0;
    end else if (rise) begin
      if (m_armed) begin
        p = cyc - m_last;
        m_period = 32'(p);
        m_valid = 1'b1;
        m_match = (EXPECT != 0) && (32'(p) == EXPECT);
        if (32'(p) < m_minp) m_minp = 32'(p);
        if (32'(p) > m_maxp) m_maxp = 32'(p);
        if (m_match) begin
          m_streak++;
          if (m_streak >= LOCK_COUNT) m_locked = 1'b1;
        end else begin
          m_streak = 0;
          m_locked = 1'b0;
        end
      end
      m_armed = 1'b1;
      m_last = cyc;
    end else if (m_armed && TMAX != 0 && 32'(cyc - m_last) >= TMAX) begin
      m_timeout = 1'b1; m_armed = 1'b0; m_streak = 0; m_locked = 1'b0;
    end
    m_prev = INP;
  endtask

  task automatic tick();
    @(posedge CLOCK);
    model_step();
    #1;
    chk("valid",   {31'd0, VALID},   {31'd0, m_valid});
    chk("period",  PERIOD,           m_period);
    chk("match",   {31'd0, MATCH},   {31'd0, m_match});
    chk("minp",    MINP,             m_minp);
    chk("maxp",    MAXP,             m_maxp);
    chk("locked",  {31'd0, LOCKED},  {31'd0, m_locked});
    chk("timeout", {31'd0, TIMEOUT}, {31'd0, m_timeout});
  endtask

  task automatic hold(input logic level, input int n);
    INP = level;
    for (int i = 0; i < n; i++) tick();
  endtask

  // One rising edge followed by a low tail; the next rise lands gap cycles later.
  task automatic pulse(input int gap);
    hold(1'b1, 1);
    hold(1'b0, gap - 1);
  endtask

  task automatic do_clear(input logic level);
    INP = level;
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
  endtask

  initial begin
    NRESET = 1'b0; INP = 1'b1; CLEAR = 1'b0; EXPECT = 32'd0; TMAX = 32'd8;
    model_reset();
    for (int i = 0; i < 3; i++) tick();
    chk("rst_minp", MINP, 32'hFFFF_FFFF);
    chk("rst_period", PERIOD, 32'd0);
    NRESET = 1'b1;

    // Level high across reset release is not an edge.
    hold(1'b1, 4);
    chk("high_no_valid", {31'd0, VALID}, 32'd0);
    hold(1'b0, 2);
    pulse(6);
    hold(1'b1, 1);
    chk("first_after_high", PERIOD, 32'd6);
    hold(1'b0, 3);

    // Steady period 10 with lock.
    do_clear(1'b0);
    TMAX = 32'd0; EXPECT = 32'd10;
    for (int i = 0; i < 6; i++) pulse(10);
    chk("locked_10", {31'd0, LOCKED}, 32'd1);
    chk("min_10", MINP, 32'd10);
    chk("max_10", MAXP, 32'd10);

    // One late pulse breaks the lock.
    pulse(13);
    hold(1'b1, 1);
    chk("late_period", PERIOD, 32'd13);
    chk("late_unlock", {31'd0, LOCKED}, 32'd0);
    chk("late_max", MAXP, 32'd13);
    hold(1'b0, 9);
    for (int i = 0; i < 5; i++) pulse(10);

    // CLEAR coincides with a rise while locked.
    do_clear(1'b1);
    chk("clr_period", PERIOD, 32'd10);
    chk("clr_minp", MINP, 32'hFFFF_FFFF);
    chk("clr_locked", {31'd0, LOCKED}, 32'd0);
    hold(1'b0, 9);
    for (int i = 0; i < 3; i++) pulse(10);

    // No comparison when EXPECT is zero.
    do_clear(1'b0);
    EXPECT = 32'd0;
    pulse(5); pulse(5); pulse(20); pulse(20); pulse(5);
    chk("noexp_min", MINP, 32'd5);
    chk("noexp_max", MAXP, 32'd20);
    chk("noexp_lock", {31'd0, LOCKED}, 32'd0);

    // Stall detection.
    TMAX = 32'd50;
    pulse(60);
    chk("stall_timeout", {31'd0, TIMEOUT}, 32'd1);
    pulse(7); pulse(7); pulse(7);
    chk("stall_sticky", {31'd0, TIMEOUT}, 32'd1);

    // Randomized trains.
    EXPECT = 32'd12; TMAX = 32'd0;
    while (cyc < 4000) begin
      int r, gap;
      r = $urandom_range(0, 39);
      if (r == 0) begin
        do_clear(1'($urandom_range(0, 1)));
      end else if (r == 1) begin
        EXPECT = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(10, 13));
      end else if (r == 2) begin
        TMAX = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(14, 30));
      end else begin
        int w;
        gap = ($urandom_range(0, 3) != 0) ? int'(EXPECT) : $urandom_range(2, 35);
        if (gap < 2) gap = $urandom_range(2, 35);
        w = $urandom_range(1, gap - 1);
        hold(1'b1, w);
        hold(1'b0, gap - w);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
